i2c_xfer_ctrl: RTL and testbench
================================

Name: i2c_xfer_ctrl

Overview:
- Transaction sequencer in front of the I2C byte-level FSM (master mode).
- Accepts one transfer request (7-bit address, direction, byte count) plus a byte stream, and issues START / WRITE / READ / STOP byte commands in order.
- Collects ACK and arbitration-lost results and reports per-transfer completion and error status.
- Sits between the host register interface and the byte FSM command port.

Parameters:
LEN_W, 8, width of byte-count field; max transfer = 2^LEN_W-1 data bytes
TIMEOUT_W, 16, width of byte-done watchdog counter (used only with I2C_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst_  input  1  synchronous reset, active-high
master  input  1  master mode enable; 0 = requests refused
req_valid  input  1  transfer request valid
req_ready  output  1  controller idle and able to accept request
req_addr  input  7  slave address
req_rw  input  1  0 = write, 1 = read
req_len  input  LEN_W  data byte count (0 = address-only probe)
wdata  input  8  write data byte
wdata_valid  input  1  wdata valid
wdata_ready  output  1  wdata consumed this cycle
rdata  output  8  read data byte
rdata_valid  output  1  one-cycle pulse, rdata valid
cmd  output  8  byte FSM command: [7] START, [6] STOP, [5] WRITE, [4] READ, [3] master NACK on read; [2:0] = 0
din  output  8  byte to transmit with WRITE
dout  input  8  byte received by READ
byte_done  input  1  one-cycle pulse, current command complete
ack  input  1  received ACK bit, valid with byte_done (0 = ACK, 1 = NACK)
al  input  1  arbitration lost, level or pulse, any cycle
busy  output  1  transfer in progress
done  output  1  one-cycle pulse at transfer end (success or error)
nack_err  output  1  sticky until next accepted request: slave NACK
al_err  output  1  sticky until next accepted request: arbitration lost
to_err  output  1  sticky until next accepted request: watchdog timeout (0 without macro)

Behaviour:
- Reset (rst_ high at clk edge): state IDLE; cmd, din, rdata = 0; req_ready = 0 during reset, then master; wdata_ready, rdata_valid, busy, done, error flags = 0.
- Reset mid-transfer: abort immediately, no STOP issued, no done pulse.
- req_ready = (state == IDLE) && master && !rst_.
- Request accept: on req_valid && req_ready, latch addr/rw/len, clear all error flags, set busy, enter START the next cycle.
- Command handshake: cmd is held constant, exactly one of bits [7:4] set, until the cycle byte_done is seen. The cycle after byte_done, cmd = 0 for at least one cycle. Then the next command is issued.
- States and transitions:
  - IDLE -> START on accept.
  - START: cmd[7]; on byte_done -> ADDR.
  - ADDR: cmd[5], din = {addr, rw}.
    - On byte_done with ack = 1: set nack_err, go to STOP.
    - Else if len = 0: go to STOP.
    - Else: go to WDATA if rw = 0, RDATA if rw = 1.
  - WDATA: wait with cmd = 0 while wdata_valid = 0 (bus stalled, no timeout accrues).
    - When wdata_valid = 1: wdata_ready = 1 for one cycle, din <= wdata, cmd[5] set.
    - On byte_done: decrement count. ack = 1 -> nack_err, STOP. Count reaches 0 -> STOP. Otherwise stay in WDATA.
  - RDATA: cmd[4]; cmd[3] = 1 on the last byte (count = 1), else 0.
    - On byte_done: rdata <= dout, rdata_valid pulse the same cycle the register updates, decrement count.
    - Count 0 -> STOP.
  - STOP: cmd[6]; on byte_done -> DONE.
  - DONE: done = 1 for one cycle, busy = 0, -> IDLE.
- al: any cycle in a non-IDLE state, al = 1 has priority over byte_done. Set al_err, cmd <= 0, no STOP, go to DONE.
- master dropping to 0 mid-transfer: ignored until IDLE.
- Counter: LEN_W bits, loaded from req_len, never wraps (decrement only when nonzero).
- busy = 1 from the cycle after accept through the DONE cycle inclusive.

Optional Feature:
- Macro I2C_TIMEOUT_EN.
- With the macro: a TIMEOUT_W-bit counter runs while cmd != 0 and resets on every new command.
  - On reaching all-ones before byte_done: set to_err, cmd <= 0, go to DONE without STOP.
  - al takes priority over timeout in the same cycle.
- Without the macro: no counter; to_err tied 0; TIMEOUT_W unused.

Test Plan:
- Write addr 0x50, len 2, wdata 0xA5, 0x3C, all ACK -> cmd sequence 0x80, 0x20 (din 0xA0), 0x20 (din 0xA5), 0x20 (din 0x3C), 0x40; one done pulse; nack_err = al_err = 0; two wdata_ready pulses.
- Read addr 0x1D, len 3, dout 0x11, 0x22, 0x33 -> din 0x3B; READ cmds 0x10, 0x10, 0x18; rdata_valid pulses with 0x11, 0x22, 0x33; STOP; done.
- Address NACK (ack = 1 on ADDR byte_done), len 4 -> nack_err = 1; next cmd 0x40 STOP; no WDATA/RDATA command; done pulse.
- al pulse during second WDATA with byte_done in the same cycle -> al_err = 1, nack_err = 0; cmd 0 next cycle; no STOP issued; done pulse; req_ready returns high.
- len 0 probe to 0x68 with ACK -> START, ADDR (din 0xD0), STOP, done; rst_ asserted mid-ADDR -> next cycle cmd = 0, busy = 0, no done.
- With I2C_TIMEOUT_EN, TIMEOUT_W = 4, byte_done withheld on START -> to_err set after 15 cycles; cmd 0; done pulse; without the macro the controller waits indefinitely.

Source files
------------

// File: rtl/i2c_xfer_ctrl.sv
// i2c_xfer_ctrl: I2C master transfer sequencer feeding the byte FSM; optional watchdog under I2C_TIMEOUT_EN
module i2c_xfer_ctrl #(
    parameter int LEN_W     = 8,
    parameter int TIMEOUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             master,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [6:0]       req_addr,
    input  logic             req_rw,
    input  logic [LEN_W-1:0] req_len,
    input  logic [7:0]       wdata,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    output logic [7:0]       rdata,
    output logic             rdata_valid,
    output logic [7:0]       cmd,
    output logic [7:0]       din,
    input  logic [7:0]       dout,
    input  logic             byte_done,
    input  logic             ack,
    input  logic             al,
    output logic             busy,
    output logic             done,
    output logic             nack_err,
    output logic             al_err,
    output logic             to_err
);
    typedef enum logic [2:0] {IDLE, START, ADDR, WDATA, RDATA, STOP, DONE} state_t;

    if (LEN_W < 1 || TIMEOUT_W < 2) begin : g_param_chk
        $error("i2c_xfer_ctrl: LEN_W must be >= 1 and TIMEOUT_W >= 2");
    end

    state_t           state_q;
    logic [6:0]       addr_q;
    logic             rw_q;
    logic [LEN_W-1:0] cnt_q;
    logic [7:0]       cmd_q, din_q, rdata_q;
    logic             rdata_valid_q, busy_q, done_q, nack_q, al_q, to_q;
    logic             issue, bd, last, to_hit;

    // a command is issued only from an idle command port, so a zero gap always follows byte_done
    assign issue       = cmd_q == 8'h00;
    assign bd          = byte_done && !issue;
    assign last        = cnt_q <= LEN_W'(1);
    assign req_ready   = state_q == IDLE && master && !rst_;
    assign wdata_ready = state_q == WDATA && issue && wdata_valid && !al && !rst_;
    assign cmd         = cmd_q;
    assign din         = din_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign nack_err    = nack_q;
    assign al_err      = al_q;
    assign to_err      = to_q;

`ifdef I2C_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_cnt_q;
    // watchdog counts cycles the current command has been outstanding
    always_ff @(posedge clk) to_cnt_q <= (rst_ || issue) ? '0 : to_cnt_q + 1'b1;
    assign to_hit = !issue && &to_cnt_q && !byte_done;
`else
    assign to_hit = 1'b0;
`endif

    // transfer sequencer: accept, issue START/ADDR/data/STOP, collect status
    always_ff @(posedge clk) begin
        rdata_valid_q <= 1'b0;
        done_q        <= 1'b0;
        if (rst_) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            cnt_q   <= '0;
            cmd_q   <= '0;
            din_q   <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            nack_q  <= 1'b0;
            al_q    <= 1'b0;
            to_q    <= 1'b0;
        end else if (state_q == IDLE) begin
            if (req_valid && req_ready) begin
                addr_q  <= req_addr;
                rw_q    <= req_rw;
                cnt_q   <= req_len;
                nack_q  <= 1'b0;
                al_q    <= 1'b0;
                to_q    <= 1'b0;
                busy_q  <= 1'b1;
                state_q <= START;
            end
        end else if (al && state_q != DONE) begin
            al_q    <= 1'b1;
            cmd_q   <= '0;
            done_q  <= 1'b1;
            state_q <= DONE;
        end else if (to_hit) begin
            to_q    <= 1'b1;
            cmd_q   <= '0;
            done_q  <= 1'b1;
            state_q <= DONE;
        end else begin
            case (state_q)
                START: begin
                    if (bd) begin
                        cmd_q   <= '0;
                        state_q <= ADDR;
                    end else if (issue) cmd_q <= 8'h80;
                end
                ADDR: begin
                    if (bd) begin
                        cmd_q   <= '0;
                        if (ack) nack_q <= 1'b1;
                        state_q <= (ack || cnt_q == '0) ? STOP : rw_q ? RDATA : WDATA;
                    end else if (issue) begin
                        cmd_q <= 8'h20;
                        din_q <= {addr_q, rw_q};
                    end
                end
                WDATA: begin
                    if (bd) begin
                        cmd_q   <= '0;
                        if (ack) nack_q <= 1'b1;
                        cnt_q   <= (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
                        state_q <= (ack || last) ? STOP : WDATA;
                    end else if (wdata_ready) begin
                        cmd_q <= 8'h20;
                        din_q <= wdata;
                    end
                end
                RDATA: begin
                    if (bd) begin
                        cmd_q         <= '0;
                        rdata_q       <= dout;
                        rdata_valid_q <= 1'b1;
                        cnt_q         <= (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
                        state_q       <= last ? STOP : RDATA;
                    end else if (issue) cmd_q <= {4'b0001, cnt_q == LEN_W'(1), 3'b000};
                end
                STOP: begin
                    if (bd) begin
                        cmd_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (issue) cmd_q <= 8'h40;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_xfer_ctrl.sv
// tb_i2c_xfer_ctrl: directed bench for the I2C transfer sequencer
module tb_i2c_xfer_ctrl;
    logic       clk = 1'b0;
    logic       rst_ = 1'b1;
    logic       master = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [6:0] req_addr = '0;
    logic       req_rw = 1'b0;
    logic [7:0] req_len = '0;
    logic [7:0] wdata = '0;
    logic       wdata_valid = 1'b0;
    logic       wdata_ready;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic [7:0] cmd, din;
    logic [7:0] dout = '0;
    logic       byte_done = 1'b0;
    logic       ack = 1'b0;
    logic       al = 1'b0;
    logic       busy, done, nack_err, al_err, to_err;
    int         chk = 0;
    int         pass = 0;
    int         done_n = 0;
    int         wr_n = 0;
    int         rv_n = 0;

    i2c_xfer_ctrl #(.LEN_W(8), .TIMEOUT_W(4)) dut (
        .clk(clk), .rst_(rst_), .master(master),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_rw(req_rw), .req_len(req_len),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid),
        .cmd(cmd), .din(din), .dout(dout), .byte_done(byte_done), .ack(ack), .al(al),
        .busy(busy), .done(done), .nack_err(nack_err), .al_err(al_err), .to_err(to_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_n++;
        if (wdata_ready) wr_n++;
        if (rdata_valid) rv_n++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    task automatic wait_cmd(output logic [7:0] c, output logic [7:0] d);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd !== 8'h00) break;
        end
        c = cmd;
        d = din;
    endtask

    task automatic pulse_done(input logic a, input logic [7:0] dv);
        byte_done = 1'b1;
        ack = a;
        dout = dv;
        @(negedge clk);
        byte_done = 1'b0;
        ack = 1'b0;
    endtask

    task automatic start_req(input logic [6:0] a, input logic rw, input logic [7:0] len);
        @(negedge clk);
        req_addr = a;
        req_rw = rw;
        req_len = len;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        chk++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready got %b exp 0", req_ready); else pass++;
        chk++; if ({cmd, din, rdata} !== 24'h0) $display("FAIL rst_regs got %h exp 000000", {cmd, din, rdata}); else pass++;
        chk++; if ({busy, done, nack_err, al_err, to_err, wdata_ready, rdata_valid} !== 7'b0)
            $display("FAIL rst_flags got %b exp 0000000", {busy, done, nack_err, al_err, to_err, wdata_ready, rdata_valid}); else pass++;
        rst_ = 1'b0;
        @(negedge clk);
        chk++; if (req_ready !== 1'b1) $display("FAIL idle_req_ready got %b exp 1", req_ready); else pass++;
        master = 1'b0;
        #1;
        chk++; if (req_ready !== 1'b0) $display("FAIL nomaster_req_ready got %b exp 0", req_ready); else pass++;
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        req_valid = 1'b0;
        chk++; if (busy !== 1'b0) $display("FAIL nomaster_busy got %b exp 0", busy); else pass++;
        master = 1'b1;
    endtask

    task automatic test_write();
        logic [7:0] ec [5];
        logic [7:0] ed [5];
        logic [7:0] c, d;
        int d0, w0;
        ec = '{8'h80, 8'h20, 8'h20, 8'h20, 8'h40};
        ed = '{8'h00, 8'hA0, 8'hA5, 8'h3C, 8'h00};
        d0 = done_n;
        w0 = wr_n;
        wdata = 8'hA5;
        wdata_valid = 1'b1;
        start_req(7'h50, 1'b0, 8'd2);
        chk++; if (busy !== 1'b1) $display("FAIL w_busy got %b exp 1", busy); else pass++;
        for (int i = 0; i < 5; i++) begin
            wait_cmd(c, d);
            chk++; if (c !== ec[i]) $display("FAIL w_cmd%0d got %h exp %h", i, c, ec[i]); else pass++;
            if (i >= 1 && i <= 3) begin
                chk++; if (d !== ed[i]) $display("FAIL w_din%0d got %h exp %h", i, d, ed[i]); else pass++;
            end
            if (i == 2) wdata = 8'h3C;
            if (i == 3) wdata_valid = 1'b0;
            pulse_done(1'b0, 8'h00);
            chk++; if (cmd !== 8'h00) $display("FAIL w_gap%0d got %h exp 00", i, cmd); else pass++;
        end
        chk++; if ({done, busy} !== 2'b11) $display("FAIL w_done_cycle got %b exp 11", {done, busy}); else pass++;
        @(negedge clk);
        chk++; if ({done, busy, req_ready} !== 3'b001) $display("FAIL w_idle got %b exp 001", {done, busy, req_ready}); else pass++;
        chk++; if (done_n - d0 !== 1) $display("FAIL w_done_count got %0d exp 1", done_n - d0); else pass++;
        chk++; if (wr_n - w0 !== 2) $display("FAIL w_wready_count got %0d exp 2", wr_n - w0); else pass++;
        chk++; if ({nack_err, al_err} !== 2'b00) $display("FAIL w_errs got %b exp 00", {nack_err, al_err}); else pass++;
    endtask

    task automatic test_read();
        logic [7:0] ec [6];
        logic [7:0] c, d;
        int r0, d0;
        ec = '{8'h80, 8'h20, 8'h10, 8'h10, 8'h18, 8'h40};
        r0 = rv_n;
        d0 = done_n;
        start_req(7'h1D, 1'b1, 8'd3);
        master = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wait_cmd(c, d);
            chk++; if (c !== ec[i]) $display("FAIL r_cmd%0d got %h exp %h", i, c, ec[i]); else pass++;
            if (i == 1) begin
                chk++; if (d !== 8'h3B) $display("FAIL r_din got %h exp 3b", d); else pass++;
            end
            pulse_done(1'b0, 8'h11 * 8'(i - 1));
            if (i >= 2 && i <= 4) begin
                chk++; if ({rdata_valid, rdata} !== {1'b1, 8'h11 * 8'(i - 1)})
                    $display("FAIL r_rdata%0d got %b/%h exp 1/%h", i, rdata_valid, rdata, 8'h11 * 8'(i - 1)); else pass++;
            end
        end
        chk++; if (done !== 1'b1) $display("FAIL r_done got %b exp 1", done); else pass++;
        master = 1'b1;
        @(negedge clk);
        chk++; if (rv_n - r0 !== 3) $display("FAIL r_rvalid_count got %0d exp 3", rv_n - r0); else pass++;
        chk++; if (done_n - d0 !== 1) $display("FAIL r_done_count got %0d exp 1", done_n - d0); else pass++;
    endtask

    task automatic test_addr_nack();
        logic [7:0] c, d;
        int w0;
        w0 = wr_n;
        wdata = 8'h55;
        wdata_valid = 1'b1;
        start_req(7'h2A, 1'b0, 8'd4);
        wait_cmd(c, d);
        pulse_done(1'b0, 8'h00);
        wait_cmd(c, d);
        chk++; if ({c, d} !== 16'h2054) $display("FAIL n_addr got %h exp 2054", {c, d}); else pass++;
        pulse_done(1'b1, 8'h00);
        chk++; if (nack_err !== 1'b1) $display("FAIL n_nack_err got %b exp 1", nack_err); else pass++;
        wait_cmd(c, d);
        chk++; if (c !== 8'h40) $display("FAIL n_stop got %h exp 40", c); else pass++;
        chk++; if (wr_n - w0 !== 0) $display("FAIL n_wready_count got %0d exp 0", wr_n - w0); else pass++;
        pulse_done(1'b0, 8'h00);
        chk++; if (done !== 1'b1) $display("FAIL n_done got %b exp 1", done); else pass++;
        wdata_valid = 1'b0;
        @(negedge clk);
        chk++; if (nack_err !== 1'b1) $display("FAIL n_sticky got %b exp 1", nack_err); else pass++;
    endtask

    task automatic test_al();
        logic [7:0] c, d;
        logic [7:0] seen;
        wdata = 8'h77;
        wdata_valid = 1'b1;
        start_req(7'h10, 1'b0, 8'd3);
        chk++; if (nack_err !== 1'b0) $display("FAIL a_nack_cleared got %b exp 0", nack_err); else pass++;
        for (int i = 0; i < 3; i++) begin
            wait_cmd(c, d);
            pulse_done(1'b0, 8'h00);
        end
        wait_cmd(c, d);
        chk++; if (c !== 8'h20) $display("FAIL a_wdata2 got %h exp 20", c); else pass++;
        al = 1'b1;
        byte_done = 1'b1;
        @(negedge clk);
        al = 1'b0;
        byte_done = 1'b0;
        wdata_valid = 1'b0;
        chk++; if (cmd !== 8'h00) $display("FAIL a_cmd got %h exp 00", cmd); else pass++;
        chk++; if ({al_err, nack_err, done} !== 3'b101) $display("FAIL a_flags got %b exp 101", {al_err, nack_err, done}); else pass++;
        seen = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen = seen | cmd;
        end
        chk++; if (seen !== 8'h00) $display("FAIL a_no_stop got %h exp 00", seen); else pass++;
        chk++; if ({busy, req_ready, al_err} !== 3'b011) $display("FAIL a_idle got %b exp 011", {busy, req_ready, al_err}); else pass++;
    endtask

    task automatic test_probe_reset();
        logic [7:0] ec [3];
        logic [7:0] c, d;
        int d0;
        ec = '{8'h80, 8'h20, 8'h40};
        start_req(7'h68, 1'b0, 8'd0);
        chk++; if (al_err !== 1'b0) $display("FAIL p_al_cleared got %b exp 0", al_err); else pass++;
        for (int i = 0; i < 3; i++) begin
            wait_cmd(c, d);
            chk++; if (c !== ec[i]) $display("FAIL p_cmd%0d got %h exp %h", i, c, ec[i]); else pass++;
            if (i == 1) begin
                chk++; if (d !== 8'hD0) $display("FAIL p_din got %h exp d0", d); else pass++;
            end
            pulse_done(1'b0, 8'h00);
        end
        chk++; if (done !== 1'b1) $display("FAIL p_done got %b exp 1", done); else pass++;
        d0 = done_n + 1;
        start_req(7'h68, 1'b0, 8'd0);
        wait_cmd(c, d);
        pulse_done(1'b0, 8'h00);
        wait_cmd(c, d);
        chk++; if (c !== 8'h20) $display("FAIL p2_addr got %h exp 20", c); else pass++;
        rst_ = 1'b1;
        #1;
        chk++; if (req_ready !== 1'b0) $display("FAIL p2_rst_ready got %b exp 0", req_ready); else pass++;
        @(negedge clk);
        rst_ = 1'b0;
        chk++; if ({cmd, busy, done} !== 10'h0) $display("FAIL p2_abort got %h/%b/%b exp 00/0/0", cmd, busy, done); else pass++;
        repeat (4) @(negedge clk);
        chk++; if (done_n !== d0) $display("FAIL p2_no_done got %0d exp %0d", done_n, d0); else pass++;
    endtask

    task automatic test_timeout();
        logic [7:0] c, d;
        start_req(7'h08, 1'b0, 8'd0);
        wait_cmd(c, d);
        chk++; if (c !== 8'h80) $display("FAIL t_start got %h exp 80", c); else pass++;
`ifdef I2C_TIMEOUT_EN
        begin
            int n;
            n = 0;
            while (done !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk++; if (n < 15 || n > 17) $display("FAIL t_cycles got %0d exp 15..17", n); else pass++;
            chk++; if ({to_err, cmd} !== 9'h100) $display("FAIL t_to_err got %b/%h exp 1/00", to_err, cmd); else pass++;
            @(negedge clk);
            chk++; if ({busy, req_ready} !== 2'b01) $display("FAIL t_idle got %b exp 01", {busy, req_ready}); else pass++;
        end
`else
        repeat (40) @(negedge clk);
        chk++; if ({cmd, to_err, busy} !== 10'b1000_0000_01) $display("FAIL t_wait got %h/%b/%b exp 80/0/1", cmd, to_err, busy); else pass++;
        pulse_done(1'b0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            wait_cmd(c, d);
            pulse_done(1'b0, 8'h00);
        end
        chk++; if ({done, to_err} !== 2'b10) $display("FAIL t_done got %b exp 10", {done, to_err}); else pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_al();
        test_probe_reset();
        test_timeout();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
